// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory arbiter.
// State encoding and default bus widths.
package mem_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    I_REQ,
    I_WAIT,
    D_REQ,
    D_WAIT
  } state_e;

endpackage

// File: rtl/mem_watchdog.sv
// Load-clear cycle counter with a terminal flag.
// Flags the TIMEOUT-th consecutive enabled cycle.
module mem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign tc = en && (cnt == CW'(TIMEOUT - 1));

  // count busy cycles, restart on every state entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory.
// One outstanding transaction, data port has priority.
module unified_mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          ivalid,
  output logic          istall,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dvalid,
  output logic          dstall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  state_e state;

  logic busy;
  logic in_req;
  logic in_wait;
  logic is_i;
  logic is_d;
  logic done_ok;
  logic tmo;
  logic fin;
  logic wd_clr;

  assign busy    = (state != IDLE);
  assign in_req  = (state == I_REQ) || (state == D_REQ);
  assign in_wait = (state == I_WAIT) || (state == D_WAIT);
  assign is_i    = (state == I_REQ) || (state == I_WAIT);
  assign is_d    = (state == D_REQ) || (state == D_WAIT);

  assign done_ok = mem_rvalid && (in_wait || (in_req && mem_gnt));
  assign fin     = busy && (done_ok || tmo);

  assign ivalid = fin && is_i;
  assign dvalid = fin && is_d;
  assign irdata = (ivalid && done_ok) ? mem_rdata : '0;
  assign drdata = (dvalid && done_ok) ? mem_rdata : '0;
  assign istall = ireq && !ivalid;
  assign dstall = dreq && !dvalid;

  assign wd_clr = !busy || (in_req && mem_gnt) || fin;

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk  (clk),
    .reset(reset),
    .clr  (wd_clr),
    .en   (busy),
    .tc   (tmo)
  );

  // transaction sequencer with registered memory-side outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (fin && !done_ok) begin
        bus_err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (dreq) begin
            mem_req   <= 1'b1;
            mem_we    <= dwe;
            mem_addr  <= daddr;
            mem_wdata <= dwdata;
            state     <= D_REQ;
          end else if (ireq) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= iaddr;
            state    <= I_REQ;
          end
        end
        I_REQ, D_REQ: begin
          if (fin) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= is_i ? I_WAIT : D_WAIT;
          end
        end
        I_WAIT, D_WAIT: begin
          if (fin) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter with a transaction-level
// model of access latency, priority and timeout.
module tb_unified_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ireq;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] irdata;
  logic          ivalid;
  logic          istall;
  logic          dreq;
  logic          dwe;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic [DW-1:0] drdata;
  logic          dvalid;
  logic          dstall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          bus_err;

  int  npass = 0;
  int  ntot  = 0;
  bit  exp_err = 1'b0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .AW(AW),
    .DW(DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ireq      (ireq),
    .iaddr     (iaddr),
    .irdata    (irdata),
    .ivalid    (ivalid),
    .istall    (istall),
    .dreq      (dreq),
    .dwe       (dwe),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .drdata    (drdata),
    .dvalid    (dvalid),
    .dstall    (dstall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot = ntot + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  // idle cycle with memory noise that must be ignored
  task automatic idle_cycle();
    @(negedge clk);
    ireq       = 1'b0;
    dreq       = 1'b0;
    mem_gnt    = 1'($urandom);
    mem_rvalid = 1'($urandom);
    mem_rdata  = $urandom;
    #1;
    chk("idle_ivalid", 32'(ivalid), 0);
    chk("idle_dvalid", 32'(dvalid), 0);
    chk("idle_irdata", irdata, 0);
    chk("idle_drdata", drdata, 0);
    chk("idle_istall", 32'(istall), 0);
    chk("idle_dstall", 32'(dstall), 0);
    chk("idle_mem_req", 32'(mem_req), 0);
    chk("idle_bus_err", 32'(bus_err), 32'(exp_err));
  endtask

  // One access starting in IDLE.
  // g: REQ cycles before the grant cycle (-1: never).
  // r: WAIT cycles up to rvalid, 0 = with grant (-1: never).
  // oth: the other port requests throughout.
  // drop: own request drops after the grant phase starts.
  task automatic access(input bit isd, input bit we,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [31:0] rd,
                        input int g, input int r,
                        input bit oth, input bit drop);
    int  nreq;
    int  nwait;
    int  n;
    bit  to;
    bit  last;
    bit  own;
    logic [31:0] own_rd;
    logic [31:0] oth_rd;
    to    = (g < 0) || (r < 0);
    nreq  = (g < 0) ? TMO : g + 1;
    nwait = (g < 0) ? 0 : ((r < 0) ? TMO : r);
    n     = 1 + nreq + nwait;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      last = (k == n - 1);
      own  = !(drop && k >= 2);
      if (isd) begin
        dreq   = own;
        dwe    = (k == 0) ? we : ~we;
        daddr  = (k == 0) ? addr : addr + 4;
        dwdata = (k == 0) ? wd : ~wd;
        ireq   = oth;
        iaddr  = $urandom;
      end else begin
        ireq   = own;
        iaddr  = (k == 0) ? addr : addr + 4;
        dreq   = 1'b0;
        dwe    = 1'($urandom);
        daddr  = $urandom;
        dwdata = $urandom;
      end
      if (k == 0) begin
        mem_gnt    = 1'($urandom);
        mem_rvalid = 1'($urandom);
      end else begin
        mem_gnt    = (g >= 0) && (k == g + 1);
        mem_rvalid = last && !to;
      end
      mem_rdata = (last && !to) ? rd : $urandom;
      #1;
      own_rd = isd ? drdata : irdata;
      oth_rd = isd ? irdata : drdata;
      chk("own_valid",
          32'(isd ? dvalid : ivalid), 32'(last));
      chk("oth_valid",
          32'(isd ? ivalid : dvalid), 0);
      chk("own_stall",
          32'(isd ? dstall : istall), 32'(own && !last));
      chk("oth_stall",
          32'(isd ? istall : dstall), 32'(isd && oth));
      chk("oth_rdata", oth_rd, 0);
      if (!(last && we && isd && !to))
        chk("own_rdata", own_rd,
            (last && !to) ? rd : 32'h0);
      chk("mem_req", 32'(mem_req),
          32'(k >= 1 && k <= nreq));
      if (k >= 1) begin
        chk("mem_addr", mem_addr, addr);
        chk("mem_we", 32'(mem_we), 32'(isd && we));
        if (isd && we)
          chk("mem_wdata", mem_wdata, wd);
      end
      chk("bus_err", 32'(bus_err), 32'(exp_err));
    end
    if (to) exp_err = 1'b1;
  endtask

  initial begin
    bit   isd;
    bit   we;
    bit   oth;
    bit   drop;
    bit   force_i;
    int   g;
    int   r;
    int   sel;

    reset      = 1'b0;
    ireq       = 1'b0;
    iaddr      = '0;
    dreq       = 1'b0;
    dwe        = 1'b0;
    daddr      = '0;
    dwdata     = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // reset state with requests pending
    @(negedge clk);
    ireq = 1'b1;
    dreq = 1'b1;
    dwe  = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_ivalid", 32'(ivalid), 0);
    chk("rst_dvalid", 32'(dvalid), 0);
    ireq  = 1'b0;
    dreq  = 1'b0;
    dwe   = 1'b0;
    reset = 1'b1;
    idle_cycle();

    // single fetch: gnt cycle 1, rvalid cycle 3
    access(0, 0, 32'h10, 0, 32'h00500113,
           0, 2, 0, 0);
    idle_cycle();

    // contention: write goes first, fetch after
    access(1, 1, 32'h100, 32'hDEADBEEF, $urandom,
           1, 1, 1, 0);
    access(0, 0, 32'h104, 0, 32'hA5A5A5A5,
           0, 1, 0, 0);

    // same-cycle grant and rvalid on a load
    access(1, 0, 32'h200, 0, 32'h12345678,
           0, 0, 0, 0);
    idle_cycle();

    // fetch address moves while busy
    access(0, 0, 32'h20, 0, 32'h11112222,
           2, 3, 0, 0);

    // requester drops mid-transaction
    access(1, 0, 32'h240, 0, 32'h0BADF00D,
           2, 2, 0, 1);

    // timeout while waiting for grant
    access(0, 0, 32'h40, 0, 32'h0, -1, 0, 0, 0);
    idle_cycle();
    idle_cycle();
    access(0, 0, 32'h44, 0, 32'hCAFE0001,
           0, 1, 0, 0);

    // timeout while waiting for rvalid
    access(1, 1, 32'h80, 32'h55AA55AA, 32'h0,
           0, -1, 0, 0);
    idle_cycle();

    // randomized traffic
    force_i = 1'b0;
    for (int t = 0; t < 150; t++) begin
      isd  = force_i ? 1'b0 : 1'($urandom);
      oth  = isd ? 1'($urandom) : 1'b0;
      we   = isd ? 1'($urandom) : 1'b0;
      drop = ($urandom_range(0, 5) == 0);
      g    = $urandom_range(0, 2);
      r    = $urandom_range(0, 3);
      sel  = $urandom_range(0, 24);
      if (sel == 0) g = -1;
      if (sel == 1) r = -1;
      access(isd, we, $urandom, $urandom, $urandom,
             g, r, oth, drop);
      force_i = oth;
      if (!force_i && $urandom_range(0, 3) == 0)
        idle_cycle();
    end

    // make sure the sticky error is set for the reset test
    access(0, 0, 32'h60, 0, 32'h0, -1, 0, 0, 0);

    // reset asserted in I_REQ
    @(negedge clk);
    ireq       = 1'b1;
    iaddr      = 32'h50;
    dreq       = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(mem_req), 1);
    chk("pre_rst_err", 32'(bus_err), 1);
    reset = 1'b0;
    #1;
    exp_err = 1'b0;
    chk("arst_mem_req", 32'(mem_req), 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_bus_err", 32'(bus_err), 0);
    chk("arst_istall", 32'(istall), 1);
    @(negedge clk);
    reset      = 1'b1;
    ireq       = 1'b0;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    #1;
    chk("late_ivalid", 32'(ivalid), 0);
    chk("late_dvalid", 32'(dvalid), 0);
    idle_cycle();

    // reset asserted in D_WAIT
    @(negedge clk);
    dreq       = 1'b1;
    dwe        = 1'b0;
    daddr      = 32'h300;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    #1;
    chk("dreq_mem_req", 32'(mem_req), 1);
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("dwait_mem_req", 32'(mem_req), 0);
    chk("dwait_dvalid", 32'(dvalid), 0);
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFEEDFACE;
    #1;
    chk("arst_dvalid", 32'(dvalid), 0);
    chk("arst_drdata", drdata, 0);
    chk("arst_d_addr", mem_addr, 0);
    chk("arst_dstall", 32'(dstall), 1);
    @(negedge clk);
    reset = 1'b1;
    dreq  = 1'b0;
    #1;
    chk("late_rv_dvalid", 32'(dvalid), 0);
    chk("late_rv_mem_req", 32'(mem_req), 0);
    idle_cycle();
    access(1, 0, 32'h304, 0, 32'h76543210,
           1, 2, 0, 0);
    idle_cycle();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
